// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode seven-segment driver with built-in prescaler,
// dead time, per-digit blanking and frame-synchronous update. Optional: LEADING_ZERO_SUPPRESS_EN.
module seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned DEAD_CYCLES = 2
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [4*NUM_DIGITS-1:0]       i_digits,
   input  logic [NUM_DIGITS-1:0]         i_blank,
   input  logic                          i_load,
   output logic [NUM_DIGITS-1:0]         o_en,
   output logic [6:0]                    o_seg,
   output logic [$clog2(NUM_DIGITS)-1:0] o_digit_idx,
   output logic                          o_frame_tick
);

   localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
   localparam int unsigned PRE_W   = $clog2(REFRESH_DIV);
   localparam int unsigned DIG_W   = 4 * NUM_DIGITS;
   localparam logic [6:0]  SEG_OFF = 7'h7F;

   logic [PRE_W-1:0]      presc;
   logic [IDX_W-1:0]      idx;
   logic [DIG_W-1:0]      pend_digits;
   logic [NUM_DIGITS-1:0] pend_blank;
   logic                  pend_valid;
   logic [DIG_W-1:0]      disp_digits;
   logic [NUM_DIGITS-1:0] disp_blank;

   logic                  slot_end;
   logic                  frame_end;
   logic                  dead;
   logic [NUM_DIGITS-1:0] eff_blank;
   logic [3:0]            cur_nib;
   logic                  cur_blank;

   // Active-low gfedcba decode
   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_comb begin
      slot_end  = (presc == PRE_W'(REFRESH_DIV - 1));
      frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
      dead      = (presc < PRE_W'(DEAD_CYCLES));
   end

`ifdef LEADING_ZERO_SUPPRESS_EN
   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  seen_nz;

   // Zero nibbles above the most significant nonzero digit go dark; digit 0 always shows
   always_comb begin
      lz_mask = '0;
      seen_nz = 1'b0;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (disp_digits[4*k +: 4] != 4'h0) begin
            seen_nz = 1'b1;
         end else if (!seen_nz) begin
            lz_mask[k] = 1'b1;
         end
      end
      eff_blank = disp_blank | lz_mask;
   end
`else
   always_comb eff_blank = disp_blank;
`endif

   // Select the nibble and blank flag of the digit currently being scanned
   always_comb begin
      cur_nib   = 4'h0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            cur_nib   = disp_digits[4*k +: 4];
            cur_blank = eff_blank[k];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         presc        <= '0;
         idx          <= '0;
         pend_digits  <= '0;
         pend_blank   <= '0;
         pend_valid   <= 1'b0;
         disp_digits  <= '0;
         disp_blank   <= '0;
         o_en         <= '1;
         o_seg        <= SEG_OFF;
         o_digit_idx  <= '0;
         o_frame_tick <= 1'b0;
      end else begin
         presc <= slot_end ? '0 : presc + PRE_W'(1);
         if (slot_end) begin
            idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
         end

         // Display regs only change on the frame boundary, so a frame is never torn
         if (frame_end) begin
            if (i_load) begin
               disp_digits <= i_digits;
               disp_blank  <= i_blank;
            end else if (pend_valid) begin
               disp_digits <= pend_digits;
               disp_blank  <= pend_blank;
            end
            pend_valid <= 1'b0;
         end else if (i_load) begin
            pend_digits <= i_digits;
            pend_blank  <= i_blank;
            pend_valid  <= 1'b1;
         end

         o_frame_tick <= frame_end;
         o_digit_idx  <= idx;
         if (dead || cur_blank) begin
            o_en  <= '1;
            o_seg <= SEG_OFF;
         end else begin
            o_en  <= ~(NUM_DIGITS'(1) << idx);
            o_seg <= hex_to_seg(cur_nib);
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 dead cycles).
// Build with +define+LEADING_ZERO_SUPPRESS_EN to exercise suppression.
module tb_seg_scan_ctrl;

   localparam int N    = 4;
   localparam int DIV  = 8;
   localparam int DEAD = 2;
   localparam int FRAME = N * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] digits = '0;
   logic [3:0]  blank = '0;
   logic        load = 1'b0;
   logic [3:0]  en;
   logic [6:0]  seg;
   logic [1:0]  didx;
   logic        tick;

   int n_checks = 0;
   int n_fail   = 0;

   seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .DEAD_CYCLES(DEAD)) dut (
      .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_blank(blank), .i_load(load),
      .o_en(en), .o_seg(seg), .o_digit_idx(didx), .o_frame_tick(tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: position within the frame is simply the edge count mod 32
   logic [6:0] seg_tab [16];
   initial begin
      seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
      seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
      seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
      seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
      seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110;
      seg_tab[15] = 7'b0001110;
   end

   int          m_n = 0;
   logic [15:0] m_disp = '0, m_pend = '0;
   logic [3:0]  m_blank = '0, m_pblank = '0;
   bit          m_pv = 0;
   bit          m_ok = 0;
   logic [3:0]  x_en;
   logic [6:0]  x_seg;
   logic [1:0]  x_idx;
   logic        x_tick;

   always @(posedge clk) begin
      if (rst) begin
         x_en = 4'hF; x_seg = 7'h7F; x_idx = 2'd0; x_tick = 1'b0;
         m_n = 0; m_disp = '0; m_pend = '0; m_blank = '0; m_pblank = '0; m_pv = 0;
      end else begin
         int p, d;
         bit blk;
         p   = m_n % DIV;
         d   = (m_n / DIV) % N;
         blk = m_blank[d];
`ifdef LEADING_ZERO_SUPPRESS_EN
         if (d > 0 && (m_disp >> (4 * d)) == 16'h0) blk = 1;
`endif
         if (p < DEAD || blk) begin
            x_en = 4'hF; x_seg = 7'h7F;
         end else begin
            x_en  = 4'hF ^ (4'b1 << d);
            x_seg = seg_tab[(m_disp >> (4 * d)) & 16'hF];
         end
         x_idx  = 2'(d);
         x_tick = (m_n % FRAME) == FRAME - 1;
         if ((m_n % FRAME) == FRAME - 1) begin
            if (load) begin m_disp = digits; m_blank = blank; end
            else if (m_pv) begin m_disp = m_pend; m_blank = m_pblank; end
            m_pv = 0;
         end else if (load) begin
            m_pend = digits; m_pblank = blank; m_pv = 1;
         end
         m_n++;
      end
      m_ok = 1;
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("model_en", 32'(en), 32'(x_en));
         chk("model_seg", 32'(seg), 32'(x_seg));
         chk("model_idx", 32'(didx), 32'(x_idx));
         chk("model_tick", 32'(tick), 32'(x_tick));
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] b);
      @(negedge clk);
      digits = v; blank = b; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic wait_tick(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!tick && cyc < 200);
      if (!tick) chk("tick_timeout", 32'(cyc), 32'(0));
   endtask

   task automatic chk_out(input string name, input logic [3:0] e_en, input logic [6:0] e_seg);
      chk({name, "_en"}, 32'(en), 32'(e_en));
      chk({name, "_seg"}, 32'(seg), 32'(e_seg));
   endtask

   initial begin
      int cyc, hits;
      // 1: reset values and dark start
      step(3);
      chk_out("rst", 4'hF, 7'h7F);
      chk("rst_tick", 32'(tick), 32'(0));
      rst = 1'b0;
      step(1); chk_out("post_rst0", 4'hF, 7'h7F);
      step(1); chk_out("post_rst1", 4'hF, 7'h7F);
      step(1); chk_out("post_rst_zero", 4'b1110, 7'b1000000);

      // 2: 1234 appears only after the boundary
      do_load(16'h1234, 4'h0);
      wait_tick(cyc);
      step(3);  chk_out("d0_4", 4'b1110, 7'b0011001);
      step(8);  chk_out("d1_3", 4'b1101, 7'b0110000);
      step(8);  chk_out("d2_2", 4'b1011, 7'b0100100);
      step(8);  chk_out("d3_1", 4'b0111, 7'b1111001);
      wait_tick(cyc);
      wait_tick(cyc);
      chk("frame_period", 32'(cyc), 32'(FRAME));

      // 3: last pending load wins
      step(4);
      do_load(16'hABCD, 4'h0);
      step(3);
      do_load(16'hEF01, 4'h0);
      wait_tick(cyc);
      hits = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         if (seg == 7'b0001000 || seg == 7'b0000011 || seg == 7'b1000110 || seg == 7'b0100001)
            hits++;
         if (i == 2)  chk_out("ef01_d0", 4'b1110, 7'b1111001);
         if (i == 26) chk_out("ef01_d3", 4'b0111, 7'b0000110);
      end
      chk("abcd_seen", 32'(hits), 32'(0));

      // 4: blanked digit 2
      do_load(16'h8888, 4'b0100);
      wait_tick(cyc);
      step(3); chk_out("b_d0", 4'b1110, 7'b0000000);
      step(14);
      for (int i = 0; i < DIV; i++) begin
         chk_out("b_d2", 4'hF, 7'h7F);
         step(1);
      end
      step(2); chk_out("b_d3", 4'b0111, 7'b0000000);

      // 5: reset mid-slot while digit 2 is lit
      do_load(16'h1234, 4'h0);
      wait_tick(cyc);
      cyc = 0;
      while (en != 4'b1011 && cyc < 100) begin step(1); cyc++; end
      chk("d2_lit_found", 32'(en), 32'(4'b1011));
      step(2);
      rst = 1'b1;
      step(1);
      chk_out("mid_rst", 4'hF, 7'h7F);
      chk("mid_rst_idx", 32'(didx), 32'(0));
      rst = 1'b0;
      step(1); chk_out("mid_rst_dark", 4'hF, 7'h7F);
      step(2); chk_out("mid_rst_d0", 4'b1110, 7'b1000000);
      step(24); chk_out("mid_rst_d3", 4'b0111, 7'b1000000);

`ifdef LEADING_ZERO_SUPPRESS_EN
      // 6: leading zero suppression
      do_load(16'h0050, 4'h0);
      wait_tick(cyc);
      step(3); chk_out("lz_d0", 4'b1110, 7'b1000000);
      step(8); chk_out("lz_d1", 4'b1101, 7'b0010010);
      step(8); chk_out("lz_d2", 4'hF, 7'h7F);
      step(8); chk_out("lz_d3", 4'hF, 7'h7F);
      do_load(16'h0000, 4'h0);
      wait_tick(cyc);
      step(3); chk_out("lz0_d0", 4'b1110, 7'b1000000);
      step(8); chk_out("lz0_d1", 4'hF, 7'h7F);
`endif

      step(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
